// File: rtl/sample_window_queue.sv
// sample_window_queue: sliding-window sample buffer for the equalizer FIR path.
// Decimates the incoming strobe stream, stores accepted samples in a dual-port
// RAM and, after each accepted write once TAPS samples are held, replays the
// newest TAPS samples oldest-first with tap index and first/last markers.
module sample_window_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int TAPS   = 1021,
    parameter int DECIM  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] smpl_in,
    input  logic                     smpl_vld,
    input  logic                     clr,
    output logic signed [DATA_W-1:0] smpl_out,
    output logic                     out_vld,
    output logic [ADDR_W-1:0]        tap_idx,
    output logic                     first,
    output logic                     last,
    output logic                     sequencing,
    output logic                     primed,
    output logic                     overrun
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [ADDR_W-1:0] TAPS_A     = ADDR_W'(TAPS);
    localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(TAPS - 1);
    localparam logic [DCNT_W-1:0] DECIM_LAST = DCNT_W'(DECIM - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                overrun_q, overrun_d;
    logic                out_vld_q, out_vld_d;
    logic [ADDR_W-1:0]   tap_idx_q, tap_idx_d;
    logic                first_q, first_d;
    logic                last_q, last_d;

    logic                accept;
    logic                win_req;
    logic                can_start;
    logic                start;
    logic [ADDR_W-1:0]   rd_addr;

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic signed [DATA_W-1:0] rdata_q;

    // Sequencer address: window base plus position within the window.
    assign rd_addr = base_q + rd_cnt_q;

    // Next-state logic: decimation, write pointer, fill level, window sequencer
    // and the registered output markers.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        rd_cnt_d  = rd_cnt_q;
        base_d    = base_q;
        overrun_d = 1'b0;
        accept    = 1'b0;
        win_req   = 1'b0;
        can_start = 1'b0;
        start     = 1'b0;
        out_vld_d = (state_q == READ);
        tap_idx_d = (state_q == READ) ? rd_cnt_q : '0;
        first_d   = (state_q == READ) && (rd_cnt_q == '0);
        last_d    = (state_q == READ) && (rd_cnt_q == LAST_A);

        if (clr) begin
            // Flush aborts any window; the strobe in this cycle is dropped.
            state_d   = IDLE;
            dcnt_d    = '0;
            wr_ptr_d  = '0;
            fill_d    = '0;
            rd_cnt_d  = '0;
            out_vld_d = 1'b0;
            tap_idx_d = '0;
            first_d   = 1'b0;
            last_d    = 1'b0;
        end else begin
            if (smpl_vld) begin
                accept = (dcnt_q == '0);
                dcnt_d = (dcnt_q == DECIM_LAST) ? '0 : dcnt_q + 1'b1;
            end

            if (accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (fill_q != TAPS_A) begin
                    fill_d = fill_q + 1'b1;
                end
                win_req = (fill_d == TAPS_A);
            end

            // A new window may start when idle, or seamlessly while the last
            // address of the current window is being issued.
            can_start = (state_q == IDLE) || (rd_cnt_q == LAST_A);
            start     = win_req && can_start;
            overrun_d = win_req && !can_start;

            if (state_q == READ) begin
                if (rd_cnt_q == LAST_A) begin
                    state_d = IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end

            if (start) begin
                state_d  = READ;
                rd_cnt_d = '0;
                base_d   = wr_ptr_d - TAPS_A;
            end
        end
    end

    // Control and output-stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            rd_cnt_q  <= '0;
            base_q    <= '0;
            overrun_q <= 1'b0;
            out_vld_q <= 1'b0;
            tap_idx_q <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers
            // update together from the values present before the edge.
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            rd_cnt_q  <= rd_cnt_d;
            base_q    <= base_d;
            overrun_q <= overrun_d;
            out_vld_q <= out_vld_d;
            tap_idx_q <= tap_idx_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    // Sample RAM: write on accepted strobes, synchronous read every cycle.
    always_ff @(posedge clk) begin
        // NOTE: the RAM and its read register have no reset; contents are only
        // observed through out_vld-gated outputs after being written.
        if (accept) begin
            mem[wr_ptr_q] <= smpl_in;
        end
        rdata_q <= mem[rd_addr];
    end

    assign smpl_out   = out_vld_q ? rdata_q : '0;
    assign out_vld    = out_vld_q;
    assign tap_idx    = tap_idx_q;
    assign first      = first_q;
    assign last       = last_q;
    assign sequencing = (state_q == READ);
    assign primed     = (fill_q == TAPS_A);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sample_window_queue.sv
// Testbench for sample_window_queue: two instances (DECIM=2 and DECIM=1, TAPS=8,
// ADDR_W=4) checked every cycle against a sample-history/output-stream model,
// plus a strobe table and directed back-to-back, overrun and flush sequences.
module tb_sample_window_queue;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int TP = 8;

    logic          clk;
    logic          rst_n;

    logic          vld2, clr2, ovld2, first2, last2, seq2, primed2, ovr2;
    logic [DW-1:0] din2, dout2;
    logic [AW-1:0] tidx2;

    logic          vld1, clr1, ovld1, first1, last1, seq1, primed1, ovr1;
    logic [DW-1:0] din1, dout1;
    logic [AW-1:0] tidx1;

    int n_vec = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    sample_window_queue #(.DATA_W(DW), .ADDR_W(AW), .TAPS(TP), .DECIM(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .smpl_in(din2), .smpl_vld(vld2), .clr(clr2),
        .smpl_out(dout2), .out_vld(ovld2), .tap_idx(tidx2), .first(first2),
        .last(last2), .sequencing(seq2), .primed(primed2), .overrun(ovr2)
    );

    sample_window_queue #(.DATA_W(DW), .ADDR_W(AW), .TAPS(TP), .DECIM(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .smpl_in(din1), .smpl_vld(vld1), .clr(clr1),
        .smpl_out(dout1), .out_vld(ovld1), .tap_idx(tidx1), .first(first1),
        .last(last1), .sequencing(seq1), .primed(primed1), .overrun(ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per unit: the last TP accepted samples (oldest first), a fill level, a
    // strobe counter for decimation, and the stream of outputs still owed.
    typedef struct {
        logic [DW-1:0] data;
        int            idx;
    } item_t;

    logic [DW-1:0] hist  [2][TP];
    item_t         expq  [2][TP];
    int            exp_n [2];
    int            fill  [2];
    int            scnt  [2];
    logic          m_vld [2];
    item_t         m_cur [2];
    logic          m_ovr [2];

    task automatic model_step(input int u, input logic vld, input logic [DW-1:0] d, input logic c);
        int decim;
        decim    = (u == 0) ? 2 : 1;
        m_ovr[u] = 1'b0;
        m_vld[u] = 1'b0;
        if (c) begin
            exp_n[u] = 0;
            fill[u]  = 0;
            scnt[u]  = 0;
            return;
        end
        if (exp_n[u] > 0) begin
            m_vld[u] = 1'b1;
            m_cur[u] = expq[u][0];
            for (int j = 0; j < TP - 1; j++) expq[u][j] = expq[u][j+1];
            exp_n[u]--;
        end
        if (vld) begin
            if (scnt[u] % decim == 0) begin
                for (int j = 0; j < TP - 1; j++) hist[u][j] = hist[u][j+1];
                hist[u][TP-1] = d;
                if (fill[u] < TP) fill[u]++;
                if (fill[u] == TP) begin
                    if (exp_n[u] == 0) begin
                        for (int j = 0; j < TP; j++) begin
                            expq[u][j].data = hist[u][j];
                            expq[u][j].idx  = j;
                        end
                        exp_n[u] = TP;
                    end else begin
                        m_ovr[u] = 1'b1;
                    end
                end
            end
            scnt[u]++;
        end
    endtask

    task automatic cmp_unit(input int u, input logic ov, input logic [DW-1:0] so,
                            input logic [AW-1:0] ti, input logic fi, input logic la,
                            input logic sq, input logic pr, input logic orn);
        string p;
        p = (u == 0) ? "d2." : "d1.";
        check({p, "out_vld"}, 32'(ov), 32'(m_vld[u]));
        check({p, "smpl_out"}, 32'(so), 32'(m_vld[u] ? m_cur[u].data : 16'd0));
        if (m_vld[u]) begin
            check({p, "tap_idx"}, 32'(ti), 32'(m_cur[u].idx));
            check({p, "first"}, 32'(fi), 32'(m_cur[u].idx == 0));
            check({p, "last"}, 32'(la), 32'(m_cur[u].idx == TP - 1));
        end else begin
            check({p, "first_idle"}, 32'(fi), 32'd0);
            check({p, "last_idle"}, 32'(la), 32'd0);
        end
        check({p, "sequencing"}, 32'(sq), 32'(exp_n[u] != 0));
        check({p, "primed"}, 32'(pr), 32'(fill[u] == TP));
        check({p, "overrun"}, 32'(orn), 32'(m_ovr[u]));
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            model_step(0, vld2, din2, clr2);
            model_step(1, vld1, din1, clr1);
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            cmp_unit(0, ovld2, dout2, tidx2, first2, last2, seq2, primed2, ovr2);
            cmp_unit(1, ovld1, dout1, tidx1, first1, last1, seq1, primed1, ovr1);
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [DW-1:0] smpl;
        logic          exp_primed;
        logic          exp_win;
    } vec_t;

    vec_t vt [18];

    task automatic pulse1(input logic [DW-1:0] v, input int gap);
        @(negedge clk);
        vld1 = 1'b1;
        din1 = v;
        @(negedge clk);
        vld1 = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    initial begin
        int got_n;
        int ovr_seen;
        int wins;
        int gap;

        for (int u = 0; u < 2; u++) begin
            exp_n[u] = 0; fill[u] = 0; scnt[u] = 0;
            m_vld[u] = 1'b0; m_ovr[u] = 1'b0;
        end

        rst_n = 1'b0;
        vld2 = 1'b0; clr2 = 1'b0; din2 = '0;
        vld1 = 1'b0; clr1 = 1'b0; din1 = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst.out_vld", 32'(ovld2 | ovld1), 32'd0);
        check("rst.smpl_out", 32'(dout2 | dout1), 32'd0);
        check("rst.tap_idx", 32'(tidx2 | tidx1), 32'd0);
        check("rst.first_last", 32'({first2, last2, first1, last1}), 32'd0);
        check("rst.sequencing", 32'(seq2 | seq1), 32'd0);
        check("rst.primed", 32'(primed2 | primed1), 32'd0);
        check("rst.overrun", 32'(ovr2 | ovr1), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Strobe table for the DECIM=2 unit: odd strobes are stored, window
        // after 15 (1,3..15) and after 17 (3,5..17), none after 16 or 18.
        vt[0]  = '{16'd1,  1'b0, 1'b0};
        vt[1]  = '{16'd2,  1'b0, 1'b0};
        vt[2]  = '{16'd3,  1'b0, 1'b0};
        vt[3]  = '{16'd4,  1'b0, 1'b0};
        vt[4]  = '{16'd5,  1'b0, 1'b0};
        vt[5]  = '{16'd6,  1'b0, 1'b0};
        vt[6]  = '{16'd7,  1'b0, 1'b0};
        vt[7]  = '{16'd8,  1'b0, 1'b0};
        vt[8]  = '{16'd9,  1'b0, 1'b0};
        vt[9]  = '{16'd10, 1'b0, 1'b0};
        vt[10] = '{16'd11, 1'b0, 1'b0};
        vt[11] = '{16'd12, 1'b0, 1'b0};
        vt[12] = '{16'd13, 1'b0, 1'b0};
        vt[13] = '{16'd14, 1'b0, 1'b0};
        vt[14] = '{16'd15, 1'b1, 1'b1};
        vt[15] = '{16'd16, 1'b1, 1'b0};
        vt[16] = '{16'd17, 1'b1, 1'b1};
        vt[17] = '{16'd18, 1'b1, 1'b0};

        for (int i = 0; i < 18; i++) begin
            got_n = 0;
            @(negedge clk);
            vld2 = 1'b1;
            din2 = vt[i].smpl;
            @(negedge clk);
            vld2 = 1'b0;
            check($sformatf("tbl%0d.primed", i + 1), 32'(primed2), 32'(vt[i].exp_primed));
            for (int c = 0; c < 19; c++) begin
                @(negedge clk);
                if (ovld2) begin
                    if (got_n < TP) begin
                        check($sformatf("tbl%0d.data%0d", i + 1, got_n), 32'(dout2),
                              32'(int'(vt[i].smpl) - 14 + 2 * got_n));
                        check($sformatf("tbl%0d.idx%0d", i + 1, got_n), 32'(tidx2), 32'(got_n));
                        check($sformatf("tbl%0d.first%0d", i + 1, got_n), 32'(first2), 32'(got_n == 0));
                        check($sformatf("tbl%0d.last%0d", i + 1, got_n), 32'(last2), 32'(got_n == TP - 1));
                    end
                    got_n++;
                end
            end
            check($sformatf("tbl%0d.win_len", i + 1), 32'(got_n), vt[i].exp_win ? 32'(TP) : 32'd0);
        end

        // Wrap: 100 random strobes -> 50 accepted windows, pointers wrap often.
        ovr_seen = 0;
        wins     = 0;
        for (int s = 0; s < 100; s++) begin
            @(negedge clk);
            vld2 = 1'b1;
            din2 = 16'($urandom);
            gap  = $urandom_range(12, 5);
            repeat (gap) begin
                @(negedge clk);
                vld2 = 1'b0;
                if (ovr2) ovr_seen++;
                if (ovld2 && first2) wins++;
            end
        end
        repeat (12) begin
            @(negedge clk);
            if (ovr2) ovr_seen++;
            if (ovld2 && first2) wins++;
        end
        check("wrap.windows", 32'(wins), 32'd50);
        check("wrap.overrun", 32'(ovr_seen), 32'd0);

        // Back-to-back on the DECIM=1 unit: prime, then strobes 8 apart.
        for (int s = 0; s < 7; s++) pulse1(16'(100 + s), 2);
        @(negedge clk);
        vld1 = 1'b1;
        din1 = 16'd107;
        @(negedge clk);
        for (int i = 1; i <= 24; i++) begin
            vld1 = (i == 8) || (i == 16);
            din1 = 16'(107 + i);
            @(negedge clk);
            check($sformatf("b2b.vld%0d", i), 32'(ovld1), 32'd1);
            check($sformatf("b2b.idx%0d", i), 32'(tidx1), 32'((i - 1) % TP));
            check($sformatf("b2b.ovr%0d", i), 32'(ovr1), 32'd0);
        end
        vld1 = 1'b0;
        repeat (12) @(negedge clk);

        // Overrun: strobes 4 apart; every second one collides with a window.
        ovr_seen = 0;
        for (int i = 0; i < 34; i++) begin
            vld1 = (i % 4 == 0) && (i < 24);
            din1 = 16'(200 + i);
            @(negedge clk);
            if (ovr1) ovr_seen++;
            check($sformatf("ovr.pulse%0d", i), 32'(ovr1), 32'((i % 8 == 4) && (i < 24)));
        end
        check("ovr.count", 32'(ovr_seen), 32'd3);
        vld1 = 1'b0;
        repeat (4) @(negedge clk);

        // Flush after three window outputs, with a strobe in the clr cycle.
        @(negedge clk);
        vld1 = 1'b1;
        din1 = 16'd300;
        @(negedge clk);
        vld1 = 1'b0;
        repeat (3) @(negedge clk);
        check("flush.pre_vld", 32'(ovld1), 32'd1);
        clr1 = 1'b1;
        vld1 = 1'b1;
        din1 = 16'hDEAD;
        @(negedge clk);
        clr1 = 1'b0;
        vld1 = 1'b0;
        check("flush.out_vld", 32'(ovld1), 32'd0);
        check("flush.primed", 32'(primed1), 32'd0);
        check("flush.seq", 32'(seq1), 32'd0);
        for (int s = 0; s < 7; s++) pulse1(16'(1000 + s), 2);
        check("flush.primed7", 32'(primed1), 32'd0);
        check("flush.nowin", 32'(ovld1), 32'd0);
        pulse1(16'd1007, 2);
        check("flush.primed8", 32'(primed1), 32'd1);
        check("flush.win_vld", 32'(ovld1), 32'd1);
        check("flush.win_first", 32'(first1), 32'd1);
        check("flush.win_data", 32'(dout1), 32'd1000);
        repeat (10) @(negedge clk);

        // Random traffic with occasional flushes on the DECIM=1 unit.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            vld1 = ($urandom_range(2, 0) == 0);
            din1 = 16'($urandom);
            clr1 = ($urandom_range(79, 0) == 0);
        end
        @(negedge clk);
        vld1 = 1'b0;
        clr1 = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
